// File: rtl/bit32_seq_divider.sv
// ---------------------------------------------------------------------------
// bit32_seq_divider
//
// Purpose:
//   A multi-cycle restoring integer divider for DIV and DIVU in the execute
//   stage. It produces one quotient bit per clock from one trial subtraction.
//   Signed operands are converted to magnitudes on entry. The result signs
//   are applied in a final FIX cycle.
//
// Ports:
//   clk_in     : clock; all state changes on the rising edge
//   rst_in     : synchronous, active-high reset
//   start_in   : request; sampled only while idle
//   signed_in  : 1 = signed DIV, 0 = unsigned DIVU; sampled with start_in
//   A_in       : dividend; sampled with start_in
//   B_in       : divisor; sampled with start_in
//   Q_out      : quotient of the last completed operation
//   R_out      : remainder of the last completed operation
//   busy_out   : high while an operation is in flight (CALC or FIX)
//   done_out   : one-cycle pulse; Q_out, R_out and err_out are valid
//   err_out    : divide-by-zero flag of the last completed operation
//
// Timing:
//   Start accepted on edge k leads to done_out high in the cycle after
//   edge k+33. A zero divisor completes on edge k itself and never raises
//   busy_out.
// ---------------------------------------------------------------------------
module bit32_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // The counter value held during the final iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] p_q,      p_d;       // partial remainder
  logic [WIDTH-1:0] d_q,      d_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] b_q,      b_d;       // divisor magnitude
  logic             q_sign_q, q_sign_d;
  logic             r_sign_q, r_sign_d;
  logic [WIDTH-1:0] q_res_q,  q_res_d;
  logic [WIDTH-1:0] r_res_q,  r_res_d;
  logic             err_q,    err_d;
  logic             done_q,   done_d;

  // ------------------------------------------------------------------------
  // Operand conditioning
  // ------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // An operand is negative only for signed requests with the MSB set.
  assign a_neg = signed_in & A_in[WIDTH-1];
  assign b_neg = signed_in & B_in[WIDTH-1];
  // -0x80000000 wraps to itself. Read as unsigned, that is the correct
  // magnitude 2^31.
  assign a_mag = a_neg ? (~A_in + 1'b1) : A_in;
  assign b_mag = b_neg ? (~B_in + 1'b1) : B_in;

  // ------------------------------------------------------------------------
  // One restoring step
  // ------------------------------------------------------------------------
  // The shifted remainder keeps the bit that leaves the top of P.
  // For unsigned divisors of 2^31 or more, P itself can reach 2^31.
  // Dropping that bit would then corrupt the quotient.
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  assign p_shift = {p_q, d_q[WIDTH-1]};
  assign trial   = p_shift - {1'b0, b_q};
  // A clear top bit means the subtraction did not borrow.
  assign q_bit   = ~trial[WIDTH];

  // ------------------------------------------------------------------------
  // Next-state / datapath logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    d_d      = d_q;
    b_d      = b_q;
    q_sign_d = q_sign_q;
    r_sign_d = r_sign_q;
    q_res_d  = q_res_q;
    r_res_d  = r_res_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (B_in == '0) begin
            // Finish at once. The FSM never leaves IDLE, so busy stays low.
            q_res_d = '1;
            r_res_d = A_in;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            // The result registers keep their values until this
            // operation completes.
            d_d      = a_mag;
            b_d      = b_mag;
            p_d      = '0;
            cnt_d    = '0;
            q_sign_d = a_neg ^ b_neg;
            r_sign_d = a_neg;
            state_d  = CALC;
          end
        end
      end

      CALC: begin
        // On a borrow, P' is smaller than the divisor, so it fits in WIDTH bits.
        p_d   = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
        d_d   = {d_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Signed DIV truncates toward zero. The remainder takes the
        // dividend's sign.
        q_res_d = q_sign_q ? (~d_q + 1'b1) : d_q;
        r_res_d = r_sign_q ? (~p_q + 1'b1) : p_q;
        err_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      d_q      <= '0;
      b_q      <= '0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      q_res_q  <= '0;
      r_res_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      d_q      <= d_d;
      b_q      <= b_d;
      q_sign_q <= q_sign_d;
      r_sign_q <= r_sign_d;
      q_res_q  <= q_res_d;
      r_res_q  <= r_res_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign Q_out    = q_res_q;
  assign R_out    = r_res_q;
  assign err_out  = err_q;
  assign done_out = done_q;
  assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_bit32_seq_divider.sv
module tb_bit32_seq_divider;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_in = 1'b0;
  logic        signed_in = 1'b0;
  logic [31:0] A_in = '0;
  logic [31:0] B_in = '0;
  logic [31:0] Q_out;
  logic [31:0] R_out;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  int n_cmp = 0;
  int n_err = 0;

  bit32_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .signed_in(signed_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .Q_out    (Q_out),
    .R_out    (R_out),
    .busy_out (busy_out),
    .done_out (done_out),
    .err_out  (err_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model. It applies the arithmetic rules directly.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    e  = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      e = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  // Waits for done_out. The caller is 1 time unit past an edge.
  // lat counts edges from the accept edge to the done cycle.
  // bcnt counts the sampled cycles with busy_out high.
  task automatic wait_done(output int lat, output int bcnt, output bit timeout);
    lat = 0;
    bcnt = 0;
    timeout = 1'b0;
    while (!done_out) begin
      if (busy_out) bcnt++;
      if (lat >= 100) begin
        timeout = 1'b1;
        return;
      end
      @(posedge clk_in); #1;
      lat++;
    end
  endtask

  // Applies one request for a single edge, then waits for completion.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output int bcnt, output bit timeout);
    @(posedge clk_in); #1;
    A_in = a; B_in = b; signed_in = sgn; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_done(lat, bcnt, timeout);
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (Q_out !== 32'd0)  begin n_err++; $display("FAIL reset_q got=%h exp=%h", Q_out, 32'd0); end
    n_cmp++; if (R_out !== 32'd0)  begin n_err++; $display("FAIL reset_r got=%h exp=%h", R_out, 32'd0); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_out); end
    n_cmp++; if (err_out !== 1'b0)  begin n_err++; $display("FAIL reset_err got=%b exp=0", err_out); end
    rst_in = 1'b0;
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_directed;
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic        ts [8];
    logic [31:0] eq, er;
    logic        ee;
    int lat, bcnt;
    bit to;
    ta[0] = 32'd100;        tb[0] = 32'd7;          ts[0] = 1'b0;
    ta[1] = 32'hFFFF_FFF9;  tb[1] = 32'd2;          ts[1] = 1'b1;
    ta[2] = 32'd7;          tb[2] = 32'hFFFF_FFFE;  ts[2] = 1'b1;
    ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;  ts[3] = 1'b1;
    ta[4] = 32'h8000_0000;  tb[4] = 32'hFFFF_FFFF;  ts[4] = 1'b0;
    ta[5] = 32'hFFFF_FFFF;  tb[5] = 32'd1;          ts[5] = 1'b0;
    ta[6] = 32'hFFFF_FFFE;  tb[6] = 32'hFFFF_FFFF;  ts[6] = 1'b0;
    ta[7] = 32'hC000_0001;  tb[7] = 32'h8000_0001;  ts[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ref_div(ta[i], tb[i], ts[i], eq, er, ee);
      run_op(ta[i], tb[i], ts[i], lat, bcnt, to);
      $display("directed %0d: A=%h B=%h s=%b -> Q=%h R=%h err=%b lat=%0d busy=%0d",
               i, ta[i], tb[i], ts[i], Q_out, R_out, err_out, lat, bcnt);
      n_cmp++; if (to) begin n_err++; $display("FAIL dir_timeout idx=%0d got=no_done exp=done", i); end
      n_cmp++; if (Q_out !== eq) begin n_err++; $display("FAIL dir_q idx=%0d got=%h exp=%h", i, Q_out, eq); end
      n_cmp++; if (R_out !== er) begin n_err++; $display("FAIL dir_r idx=%0d got=%h exp=%h", i, R_out, er); end
      n_cmp++; if (err_out !== ee) begin n_err++; $display("FAIL dir_err idx=%0d got=%b exp=%b", i, err_out, ee); end
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL dir_latency idx=%0d got=%0d exp=33", i, lat); end
      n_cmp++; if (bcnt != 33) begin n_err++; $display("FAIL dir_busy_cycles idx=%0d got=%0d exp=33", i, bcnt); end
      @(posedge clk_in); #1;
      n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL dir_done_width idx=%0d got=%b exp=0", i, done_out); end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    bit to;
    run_op(32'd5, 32'd0, 1'b0, lat, bcnt, to);
    $display("div_zero: Q=%h R=%h err=%b lat=%0d busy=%0d", Q_out, R_out, err_out, lat, bcnt);
    n_cmp++; if (to) begin n_err++; $display("FAIL dz_timeout got=no_done exp=done"); end
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL dz_latency got=%0d exp=0", lat); end
    n_cmp++; if (Q_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_q got=%h exp=ffffffff", Q_out); end
    n_cmp++; if (R_out !== 32'd5) begin n_err++; $display("FAIL dz_r got=%h exp=%h", R_out, 32'd5); end
    n_cmp++; if (err_out !== 1'b1) begin n_err++; $display("FAIL dz_err got=%b exp=1", err_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL dz_busy got=%b exp=0", busy_out); end
    @(posedge clk_in); #1;
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL dz_done_width got=%b exp=0", done_out); end
    n_cmp++; if (err_out !== 1'b1) begin n_err++; $display("FAIL dz_err_hold got=%b exp=1", err_out); end
    run_op(32'd9, 32'd3, 1'b0, lat, bcnt, to);
    $display("after_dz: Q=%h R=%h err=%b lat=%0d", Q_out, R_out, err_out, lat);
    n_cmp++; if (to) begin n_err++; $display("FAIL dz2_timeout got=no_done exp=done"); end
    n_cmp++; if (Q_out !== 32'd3) begin n_err++; $display("FAIL dz2_q got=%h exp=%h", Q_out, 32'd3); end
    n_cmp++; if (R_out !== 32'd0) begin n_err++; $display("FAIL dz2_r got=%h exp=%h", R_out, 32'd0); end
    n_cmp++; if (err_out !== 1'b0) begin n_err++; $display("FAIL dz2_err got=%b exp=0", err_out); end
  endtask

  task automatic test_start_ignored;
    logic [31:0] eq, er;
    logic        ee;
    int lat, bcnt;
    bit to;
    ref_div(32'd1000, 32'd33, 1'b0, eq, er, ee);
    @(posedge clk_in); #1;
    A_in = 32'd1000; B_in = 32'd33; signed_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (5) begin @(posedge clk_in); #1; end
    A_in = 32'hFFFF_FFF0; B_in = 32'd3; signed_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_done(lat, bcnt, to);
    lat = lat + 6;
    $display("start_ignored: Q=%h R=%h err=%b lat=%0d", Q_out, R_out, err_out, lat);
    n_cmp++; if (to) begin n_err++; $display("FAIL ign_timeout got=no_done exp=done"); end
    n_cmp++; if (Q_out !== eq) begin n_err++; $display("FAIL ign_q got=%h exp=%h", Q_out, eq); end
    n_cmp++; if (R_out !== er) begin n_err++; $display("FAIL ign_r got=%h exp=%h", R_out, er); end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL ign_latency got=%0d exp=33", lat); end
    @(posedge clk_in); #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL ign_no_restart got=%b exp=0", busy_out); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(posedge clk_in); #1;
    A_in = 32'd12345; B_in = 32'd11; signed_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (10) begin @(posedge clk_in); #1; end
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    $display("reset_mid: busy=%b done=%b Q=%h R=%h err=%b", busy_out, done_out, Q_out, R_out, err_out);
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL rmid_done got=%b exp=0", done_out); end
    n_cmp++; if (Q_out !== 32'd0) begin n_err++; $display("FAIL rmid_q got=%h exp=0", Q_out); end
    n_cmp++; if (R_out !== 32'd0) begin n_err++; $display("FAIL rmid_r got=%h exp=0", R_out); end
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      if (done_out || busy_out) pulses++;
      @(posedge clk_in); #1;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rmid_late_activity got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q1, r1, q2, r2;
    logic        e1, e2;
    int lat, bcnt;
    bit to;
    ref_div(32'd77777, 32'd123, 1'b0, q1, r1, e1);
    ref_div(32'hFFFF_0000, 32'd1000, 1'b1, q2, r2, e2);
    run_op(32'd77777, 32'd123, 1'b0, lat, bcnt, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b1_timeout got=no_done exp=done"); end
    n_cmp++; if (Q_out !== q1) begin n_err++; $display("FAIL b2b1_q got=%h exp=%h", Q_out, q1); end
    // Issue the next request in the done cycle.
    A_in = 32'hFFFF_0000; B_in = 32'd1000; signed_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", busy_out); end
    n_cmp++; if (Q_out !== q1) begin n_err++; $display("FAIL b2b_hold_q got=%h exp=%h", Q_out, q1); end
    n_cmp++; if (R_out !== r1) begin n_err++; $display("FAIL b2b_hold_r got=%h exp=%h", R_out, r1); end
    wait_done(lat, bcnt, to);
    $display("back_to_back: Q=%h R=%h err=%b lat=%0d", Q_out, R_out, err_out, lat);
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b2_timeout got=no_done exp=done"); end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL b2b2_latency got=%0d exp=33", lat); end
    n_cmp++; if (Q_out !== q2) begin n_err++; $display("FAIL b2b2_q got=%h exp=%h", Q_out, q2); end
    n_cmp++; if (R_out !== r2) begin n_err++; $display("FAIL b2b2_r got=%h exp=%h", R_out, r2); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er;
    logic        s, ee;
    int lat, bcnt, sel;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 5)  b = $urandom_range(1, 300);
      else if (sel < 7)  b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else               b = $urandom;
      if (b == 32'd0 && sel != 0) b = 32'd1;
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er, ee);
      run_op(a, b, s, lat, bcnt, to);
      $display("random %0d: A=%h B=%h s=%b -> Q=%h R=%h err=%b lat=%0d", i, a, b, s, Q_out, R_out, err_out, lat);
      n_cmp++; if (to) begin n_err++; $display("FAIL rnd_timeout idx=%0d got=no_done exp=done", i); end
      n_cmp++; if (Q_out !== eq) begin n_err++; $display("FAIL rnd_q idx=%0d got=%h exp=%h", i, Q_out, eq); end
      n_cmp++; if (R_out !== er) begin n_err++; $display("FAIL rnd_r idx=%0d got=%h exp=%h", i, R_out, er); end
      n_cmp++; if (err_out !== ee) begin n_err++; $display("FAIL rnd_err idx=%0d got=%b exp=%b", i, err_out, ee); end
      n_cmp++; if (lat != (ee ? 0 : 33)) begin n_err++; $display("FAIL rnd_latency idx=%0d got=%0d exp=%0d", i, lat, ee ? 0 : 33); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
